// File: rtl/axo_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port,
// with a registered write stage and a 32-entry pending-write scoreboard.
module axo_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_din,
  input  logic                 mark_en,
  input  logic [4:0]           mark_rd,
  output logic [31:0]          busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_din_q, rf_din_d;
  logic [31:0]     busy_q, busy_d;

  logic [4:0]      rd_arr   [NREQ];
  logic [XLEN-1:0] data_arr [NREQ];
  logic [NREQ-1:0] grant;
  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   sel;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rd_arr[i]   = req_rd[5*i +: 5];
      data_arr[i] = req_data[XLEN*i +: XLEN];
    end
  end

  // Scan from the pointer, wrapping modulo NREQ; the first valid requester wins.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    grant     = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = (int'(ptr_q) + k >= NREQ) ? PW'(int'(ptr_q) + k - NREQ) : PW'(int'(ptr_q) + k);
      if (!gnt_found && req_valid[sel]) begin
        gnt_found  = 1'b1;
        gnt_idx    = sel;
        grant[sel] = 1'b1;
      end
    end
    if (rst) begin
      grant     = '0;
      gnt_found = 1'b0;
    end
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d    = ptr_q;
    rf_we_d  = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_din_d = rf_din_q;
    if (gnt_found) begin
      ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      // An accepted rd=0 request consumes its slot but never writes x0.
      if (rd_arr[gnt_idx] != 5'd0) begin
        rf_we_d  = 1'b1;
        rf_rd_d  = rd_arr[gnt_idx];
        rf_din_d = data_arr[gnt_idx];
      end
    end
  end

  // Clear before set so a same-edge mark of the retiring index keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q)
      busy_d[rf_rd_q] = 1'b0;
    if (mark_en && (mark_rd != 5'd0))
      busy_d[mark_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= 5'd0;
      rf_din_q <= '0;
      busy_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_din_q <= rf_din_d;
      busy_q   <= busy_d;
    end
  end

  assign rf_we  = rf_we_q;
  assign rf_rd  = rf_rd_q;
  assign rf_din = rf_din_q;
  assign busy   = busy_q;

endmodule
